// File: rtl/guess_round_ctrl.sv
// Match-level sequencer for the guessing game: runs ROUNDS rounds, tallies results,
// enforces a per-round timeout and picks the guess speed (boosted after a win streak).
module guess_round_ctrl #(
  parameter int ROUNDS        = 5,
  parameter int RESULT_TICKS  = 8,
  parameter int TIMEOUT_TICKS = 64,
  parameter int STREAK_BOOST  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       tick,
  input  logic       win,
  input  logic       lose,
  input  logic       hard_sw,
  output logic       game_rst,
  output logic       speed_sel,
  output logic [3:0] wins,
  output logic [3:0] losses,
  output logic [3:0] round,
  output logic       last_win,
  output logic       done
);

  localparam int MAX_TICKS = (RESULT_TICKS > TIMEOUT_TICKS) ? RESULT_TICKS : TIMEOUT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS) + 1;
  localparam int SW        = $clog2(STREAK_BOOST + 1);

  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] RESULT_LAST  = CW'(RESULT_TICKS - 1);
  localparam logic [SW-1:0] STREAK_MAX   = SW'(STREAK_BOOST);
  localparam logic [3:0]    LAST_ROUND   = 4'(ROUNDS);

  typedef enum logic [1:0] {IDLE, PLAY, RESULT, OVER} state_t;

  state_t        state;
  logic          start_d, win_d, lose_d;
  logic [CW-1:0] tick_cnt;
  logic [SW-1:0] streak;
  logic          boost;

  logic          start_rise, win_rise, lose_rise;
  logic          timeout;
  logic [SW-1:0] streak_inc;

  assign start_rise = start & ~start_d;
  assign win_rise   = win & ~win_d;
  assign lose_rise  = lose & ~lose_d;
  assign timeout    = tick && (tick_cnt == TIMEOUT_LAST);
  assign streak_inc = (streak == STREAK_MAX) ? STREAK_MAX : streak + SW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      // Edge history starts high so a level already asserted at release never fires.
      start_d   <= 1'b1;
      win_d     <= 1'b1;
      lose_d    <= 1'b1;
      tick_cnt  <= '0;
      streak    <= '0;
      boost     <= 1'b0;
      game_rst  <= 1'b1;
      speed_sel <= 1'b0;
      wins      <= 4'd0;
      losses    <= 4'd0;
      round     <= 4'd0;
      last_win  <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_d <= start;
      win_d   <= win;
      lose_d  <= lose;

      case (state)
        IDLE, OVER: begin
          if (start_rise) begin
            state     <= PLAY;
            wins      <= 4'd0;
            losses    <= 4'd0;
            streak    <= '0;
            boost     <= 1'b0;
            round     <= 4'd1;
            tick_cnt  <= '0;
            game_rst  <= 1'b0;
            done      <= 1'b0;
            speed_sel <= hard_sw;
          end
        end

        PLAY: begin
          // A simultaneous win/lose edge, or running out of time, counts as a loss.
          if (lose_rise || (timeout && !win_rise)) begin
            state    <= RESULT;
            losses   <= (losses == 4'hF) ? losses : losses + 4'd1;
            streak   <= '0;
            boost    <= 1'b0;
            last_win <= 1'b0;
            tick_cnt <= '0;
            game_rst <= 1'b1;
          end else if (win_rise) begin
            state    <= RESULT;
            wins     <= (wins == 4'hF) ? wins : wins + 4'd1;
            streak   <= streak_inc;
            if (streak_inc == STREAK_MAX) begin
              boost <= 1'b1;
            end
            last_win <= 1'b1;
            tick_cnt <= '0;
            game_rst <= 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end

        RESULT: begin
          if (tick) begin
            if (tick_cnt == RESULT_LAST) begin
              tick_cnt <= '0;
              if (round == LAST_ROUND) begin
                state <= OVER;
                done  <= 1'b1;
              end else begin
                state     <= PLAY;
                round     <= round + 4'd1;
                game_rst  <= 1'b0;
                speed_sel <= hard_sw | boost;
              end
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Bench for guess_round_ctrl: a result-history model checked every cycle, plus
// directed literal expectations walking two matches and a mid-match reset.
module tb_guess_round_ctrl;

  localparam int ROUNDS        = 5;
  localparam int RESULT_TICKS  = 8;
  localparam int TIMEOUT_TICKS = 64;
  localparam int STREAK_BOOST  = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic       hard_sw = 1'b0;
  logic       game_rst, speed_sel, last_win, done;
  logic [3:0] wins, losses, round;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  guess_round_ctrl #(
    .ROUNDS(ROUNDS), .RESULT_TICKS(RESULT_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS), .STREAK_BOOST(STREAK_BOOST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tick(tick), .win(win),
    .lose(lose), .hard_sw(hard_sw), .game_rst(game_rst), .speed_sel(speed_sel),
    .wins(wins), .losses(losses), .round(round), .last_win(last_win), .done(done)
  );

  // Model: phase 0 idle, 1 playing, 2 showing result, 3 match over.
  // Tallies, streak and boost are all derived from the list of round outcomes.
  int m_phase = 0;
  bit m_results[$];
  int m_round = 0;
  int m_t = 0;
  bit m_speed = 0, m_done = 0, m_last = 0;
  bit m_ps = 1, m_pw = 1, m_pl = 1;

  function automatic int tally(bit v);
    int n = 0;
    foreach (m_results[i]) if (m_results[i] == v) n++;
    return (n > 15) ? 15 : n;
  endfunction

  function automatic int trailing_wins();
    int n = 0;
    for (int i = m_results.size() - 1; i >= 0; i--) begin
      if (!m_results[i]) break;
      n++;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit sr, wr, lr;
    if (!reset_n) begin
      m_phase = 0; m_results.delete(); m_round = 0; m_t = 0;
      m_speed = 0; m_done = 0; m_last = 0;
      m_ps = 1; m_pw = 1; m_pl = 1;
    end else begin
      sr = start && !m_ps;
      wr = win && !m_pw;
      lr = lose && !m_pl;
      m_ps = start; m_pw = win; m_pl = lose;
      case (m_phase)
        0, 3: if (sr) begin
          m_results.delete(); m_round = 1; m_t = 0;
          m_speed = hard_sw; m_done = 0; m_phase = 1;
        end
        1: if (wr || lr || (tick && m_t == TIMEOUT_TICKS - 1)) begin
          m_last = wr && !lr;
          m_results.push_back(m_last);
          m_t = 0; m_phase = 2;
        end else if (tick) m_t++;
        2: if (tick) begin
          if (m_t == RESULT_TICKS - 1) begin
            m_t = 0;
            if (m_round == ROUNDS) begin
              m_phase = 3; m_done = 1;
            end else begin
              m_round++; m_phase = 1;
              m_speed = hard_sw || (trailing_wins() >= STREAK_BOOST);
            end
          end else m_t++;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_game_rst", 8'(game_rst), 8'(m_phase != 1));
      chk("m_speed_sel", 8'(speed_sel), 8'(m_speed));
      chk("m_wins", 8'(wins), 8'(tally(1'b1)));
      chk("m_losses", 8'(losses), 8'(tally(1'b0)));
      chk("m_round", 8'(round), 8'(m_round));
      chk("m_last_win", 8'(last_win), 8'(m_last));
      chk("m_done", 8'(done), 8'(m_done));
    end
  end

  task automatic run_ticks(int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_game_rst"}, 8'(game_rst), 8'd1);
    chk({tag, "_speed_sel"}, 8'(speed_sel), 8'd0);
    chk({tag, "_wins"}, 8'(wins), 8'd0);
    chk({tag, "_losses"}, 8'(losses), 8'd0);
    chk({tag, "_round"}, 8'(round), 8'd0);
    chk({tag, "_last_win"}, 8'(last_win), 8'd0);
    chk({tag, "_done"}, 8'(done), 8'd0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_round", 8'(round), 8'd0);

    // Match 1, slow switch: W W W (boost) L(tie) L
    hard_sw = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    $display("txn start match1: round=%0d game_rst=%0d speed=%0d", round, game_rst, speed_sel);
    chk("m1_round1", 8'(round), 8'd1);
    chk("m1_play_rst", 8'(game_rst), 8'd0);
    chk("m1_speed", 8'(speed_sel), 8'd0);

    @(negedge clk);
    win = 1'b1; @(negedge clk); win = 1'b0;
    $display("txn win r1: wins=%0d last_win=%0d", wins, last_win);
    chk("r1_wins", 8'(wins), 8'd1);
    chk("r1_last", 8'(last_win), 8'd1);
    chk("r1_rst", 8'(game_rst), 8'd1);
    tick = 1'b1;
    repeat (7) @(negedge clk);
    chk("r1_hold_round", 8'(round), 8'd1);
    @(negedge clk); tick = 1'b0;
    $display("txn result r1 done: round=%0d game_rst=%0d", round, game_rst);
    chk("r2_round", 8'(round), 8'd2);
    chk("r2_rst", 8'(game_rst), 8'd0);

    start = 1'b1; tick = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; tick = 1'b0;
    chk("r2_start_ignored", 8'(round), 8'd2);
    win = 1'b1; @(negedge clk); win = 1'b0;
    run_ticks(RESULT_TICKS);
    $display("txn win r2: wins=%0d round=%0d", wins, round);

    win = 1'b1; @(negedge clk); win = 1'b0;
    run_ticks(RESULT_TICKS);
    $display("txn win r3: wins=%0d round=%0d speed=%0d", wins, round, speed_sel);
    chk("r4_round", 8'(round), 8'd4);
    chk("r4_boost_speed", 8'(speed_sel), 8'd1);

    win = 1'b1; lose = 1'b1; @(negedge clk); win = 1'b0; lose = 1'b0;
    $display("txn tie r4: wins=%0d losses=%0d last_win=%0d", wins, losses, last_win);
    chk("r4_tie_losses", 8'(losses), 8'd1);
    chk("r4_tie_wins", 8'(wins), 8'd3);
    chk("r4_tie_last", 8'(last_win), 8'd0);
    run_ticks(RESULT_TICKS);
    chk("r5_round", 8'(round), 8'd5);
    chk("r5_speed", 8'(speed_sel), 8'd0);

    lose = 1'b1; @(negedge clk); lose = 1'b0;
    run_ticks(RESULT_TICKS);
    repeat (3) @(negedge clk);
    $display("txn match1 over: wins=%0d losses=%0d round=%0d done=%0d", wins, losses, round, done);
    chk("m1_done", 8'(done), 8'd1);
    chk("m1_wins", 8'(wins), 8'd3);
    chk("m1_losses", 8'(losses), 8'd2);
    chk("m1_final_round", 8'(round), 8'd5);

    // Match 2, fast switch: every round times out
    hard_sw = 1'b1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    $display("txn start match2: round=%0d speed=%0d done=%0d", round, speed_sel, done);
    chk("m2_round", 8'(round), 8'd1);
    chk("m2_speed", 8'(speed_sel), 8'd1);
    chk("m2_wins_clr", 8'(wins), 8'd0);
    chk("m2_losses_clr", 8'(losses), 8'd0);
    chk("m2_done_clr", 8'(done), 8'd0);
    tick = 1'b1;
    repeat (TIMEOUT_TICKS) @(negedge clk);
    $display("txn timeout r1: losses=%0d game_rst=%0d", losses, game_rst);
    chk("to_losses", 8'(losses), 8'd1);
    chk("to_rst", 8'(game_rst), 8'd1);
    repeat (ROUNDS * (TIMEOUT_TICKS + RESULT_TICKS) - TIMEOUT_TICKS) @(negedge clk);
    tick = 1'b0;
    $display("txn match2 over: losses=%0d round=%0d done=%0d", losses, round, done);
    chk("m2_done", 8'(done), 8'd1);
    chk("m2_losses", 8'(losses), 8'd5);
    chk("m2_round_final", 8'(round), 8'd5);

    start = 1'b1; @(negedge clk); start = 1'b0;
    $display("txn restart: round=%0d losses=%0d done=%0d", round, losses, done);
    chk("m3_round", 8'(round), 8'd1);
    chk("m3_losses", 8'(losses), 8'd0);
    chk("m3_done", 8'(done), 8'd0);

    // Reset while showing a result, with start held through release
    win = 1'b1; @(negedge clk); win = 1'b0;
    run_ticks(3);
    #2 reset_n = 1'b0; start = 1'b1;
    #1 chk_reset_vals("async_rst");
    $display("txn async reset: round=%0d game_rst=%0d", round, game_rst);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_start_round", 8'(round), 8'd0);
    chk("held_start_rst", 8'(game_rst), 8'd1);
    start = 1'b0; @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    $display("txn repress start: round=%0d game_rst=%0d speed=%0d", round, game_rst, speed_sel);
    chk("repress_round", 8'(round), 8'd1);
    chk("repress_rst", 8'(game_rst), 8'd0);
    chk("repress_speed", 8'(speed_sel), 8'd1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
Match-level sequencer for the guessing game. It sits between the debounced buttons and clock-divider ticks on one side and the guess FSM on the other. It holds the guess FSM in reset between rounds and runs a fixed number of rounds. It counts wins and losses, enforces a per-round timeout, and selects the guess speed, auto-boosting to the fast speed after a win streak.

Parameters:
ROUNDS, 5, rounds per match (1..15)
RESULT_TICKS, 8, tick enables that a win/lose result is shown before the next round
TIMEOUT_TICKS, 64, tick enables allowed per round before a forced loss
STREAK_BOOST, 3, consecutive wins that force fast speed

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  debounced start button (level); rising edge used
tick  in  1  one-cycle enable from the divider counter
win  in  1  guess FSM win flag (level, clk-synchronous)
lose  in  1  guess FSM lose flag (level, clk-synchronous)
hard_sw  in  1  user difficulty switch, 1 = fast
game_rst  out  1  active-high reset to the guess FSM
speed_sel  out  1  divider-mux select, 1 = fast clock
wins  out  4  match win count, saturating at 15
losses  out  4  match loss count, saturating at 15
round  out  4  current round number (1..ROUNDS); 0 in IDLE
last_win  out  1  1 = last round result was a win
done  out  1  match finished

Behaviour:
- Reset (reset_n=0, async):
  - Outputs: game_rst=1, speed_sel=0, wins=0, losses=0, round=0, last_win=0, done=0.
  - State: IDLE; internal tick counter, streak and boost cleared.
  - Edge-detect registers: start_d=1, win_d=1, lose_d=1, so a held button or flag at release does not fire.
- Edge detect: x_rise = x & ~x_d. Registers update every clk cycle.
- States are IDLE, PLAY, RESULT, OVER.
- IDLE:
  - game_rst=1.
  - start_rise -> PLAY.
  - On that transition: wins=0, losses=0, streak=0, boost=0, round=1, tick counter=0.
- PLAY:
  - game_rst=0.
  - speed_sel=hard_sw|boost, latched on PLAY entry and held constant for the whole round.
  - Tick counter increments on tick.
  - win_rise -> RESULT, wins++ (saturating), streak++ (saturating at STREAK_BOOST), last_win=1. If streak reaches STREAK_BOOST, boost=1.
  - lose_rise -> RESULT, losses++ (saturating), streak=0, boost=0, last_win=0.
  - win_rise and lose_rise in the same cycle: treated as a lose.
  - Timeout: tick with counter==TIMEOUT_TICKS-1 and no win/lose edge in that cycle -> treated as a lose.
  - Tick counter is cleared on exit from PLAY.
- RESULT:
  - game_rst=1.
  - Tick counter counts ticks. At the tick where counter==RESULT_TICKS-1:
    - if round==ROUNDS -> OVER;
    - else round++, tick counter=0 -> PLAY.
  - win/lose edges are ignored.
- OVER:
  - done=1, game_rst=1. wins, losses, round and last_win hold their values.
  - start_rise -> PLAY with the same clearing as IDLE->PLAY; done=0 on that transition.
- start_rise in PLAY or RESULT is ignored.
- All transitions take effect on the clk edge where the condition is sampled. Outputs are registered with one-cycle latency from the input event.
- speed_sel holds its last value outside PLAY.
- Counter width: ceil(log2(max(RESULT_TICKS, TIMEOUT_TICKS)))+1 bits; no wrap occurs within a state.
- Mid-operation reset: immediate return to reset values regardless of state.

Test Plan:
- Reset, then start pulse -> next cycle state PLAY, round=1, game_rst=0, wins=losses=0; speed_sel equals hard_sw.
- In PLAY, win rises -> wins=1, last_win=1, game_rst=1. After 8 ticks -> round=2, game_rst=0.
- win and lose rise in the same cycle -> losses=1, wins unchanged, last_win=0, streak cleared.
- hard_sw=0, three consecutive wins -> speed_sel=1 from round 4 entry. A following loss -> speed_sel=0 at the next round entry.
- No result for 64 ticks -> losses++, RESULT. Over 5 rounds of timeouts -> losses=5, done=1, round=5. start -> counters cleared, round=1, done=0.
- Assert reset_n mid-RESULT -> all outputs return to reset values asynchronously. start held high through reset release -> no match start until start is released and pressed again.
